// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
package key_debounce_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPressChk,
    StHeld,
    StLong,
    StRelChk
  } key_state_e;

  localparam int unsigned MinCntWidth = 1;

  // Bits needed to hold (max period - 1) for the shared per-channel counter.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : MinCntWidth;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop sync, stable-time FSM, registered level and pulses.
// Auto-repeat in the long-press state is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1_000_000,
  parameter int unsigned LongCycles     = 50_000_000,
  parameter int unsigned RepeatCycles   = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,      // already normalised: 1 = pressed
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles, LongCycles, RepeatCycles);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LongCycles - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(RepeatCycles - 1);
`endif

  logic [1:0]      sync_q;
  key_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            p;

  assign p = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b00;
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // A change of the synced pin always wins over a counter terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p) begin
          state_d = StPressChk;
          cnt_d   = '0;
        end
      end
      StPressChk: begin
        if (!p) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (!p) begin
          state_d = StRelChk;
          cnt_d   = '0;
        end else if (cnt_q == LongLast) begin
          state_d = StLong;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLong: begin
        if (!p) begin
          state_d = StRelChk;
          cnt_d   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt_q == RepLast) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
`endif
      end
      StRelChk: begin
        if (p) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: polarity normalisation plus one channel per key.
// Define KEY_REPEAT_EN to enable auto-repeat press pulses while a key is long-held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic                Sys_CLK,
  input  logic                Sys_RST,
  input  logic [NUM_KEYS-1:0] Key,
  output logic [NUM_KEYS-1:0] Key_Level,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [NUM_KEYS-1:0] Key_Long
);

  logic [NUM_KEYS-1:0] key_pressed;

  assign key_pressed = (KEY_ACTIVE_LOW != 0) ? ~Key : Key;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .LongCycles    (LONG_CYCLES),
      .RepeatCycles  (REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (Sys_CLK),
      .rst_ni   (Sys_RST),
      .key_i    (key_pressed[g]),
      .level_o  (Key_Level[g]),
      .press_o  (Key_Press[g]),
      .release_o(Key_Release[g]),
      .long_o   (Key_Long[g])
    );
  end

endmodule
